// File: rtl/sequenciador_instrucao.sv
// Instruction sequencer: fetch/decode/execute control FSM with multi-cycle ALU handshake and memory-clear sweep.
// Define SEQ_ALU_TIMEOUT_EN to enable the WAIT_ALU watchdog that sets the sticky Erro flag.
module sequenciador_instrucao #(
   parameter int PC_W      = 4,
   parameter int CLR_DEPTH = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         Start,
   input  logic [15:0]                  InstrData,
   input  logic                         AluDone,
   output logic [PC_W-1:0]              InstrAddr,
   output logic                         IrLoad,
   output logic [2:0]                   OpCode,
   output logic                         AluStart,
   output logic                         RegWrStrobe,
   output logic                         MemStrobe,
   output logic [$clog2(CLR_DEPTH)-1:0] ClearAddr,
   output logic                         ClearWe,
   output logic                         Busy,
   output logic                         Halted,
   output logic                         Erro
);

   localparam int CA_W = $clog2(CLR_DEPTH);
   localparam logic [CA_W-1:0] CLR_LAST = CA_W'(CLR_DEPTH - 1);

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_MUL   = 3'b011;
   localparam logic [2:0] OP_CLEAR = 3'b100;
   localparam logic [2:0] OP_STOP  = 3'b101;
   localparam logic [2:0] OP_READ  = 3'b110;
   localparam logic [2:0] OP_WRITE = 3'b111;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      EXEC     = 4'd3,
      WAIT_ALU = 4'd4,
      MEM      = 4'd5,
      CLEAR    = 4'd6,
      WB       = 4'd7,
      HALT     = 4'd8
   } state_t;

   state_t state;

   // Only the opcode field of the instruction word matters to the sequencer.
   logic [12:0] unused_instr_bits;
   assign unused_instr_bits = InstrData[12:0];

`ifdef SEQ_ALU_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   logic [TO_W-1:0] wait_cnt;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
`endif

   // Sequencer FSM; each strobe is registered and set on the edge that enters its owning state.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= IDLE;
         InstrAddr   <= '0;
         OpCode      <= 3'b000;
         ClearAddr   <= '0;
         IrLoad      <= 1'b0;
         AluStart    <= 1'b0;
         RegWrStrobe <= 1'b0;
         MemStrobe   <= 1'b0;
         ClearWe     <= 1'b0;
         Busy        <= 1'b0;
         Halted      <= 1'b0;
         Erro        <= 1'b0;
`ifdef SEQ_ALU_TIMEOUT_EN
         wait_cnt    <= '0;
`endif
      end else begin
         IrLoad      <= 1'b0;
         AluStart    <= 1'b0;
         RegWrStrobe <= 1'b0;
         MemStrobe   <= 1'b0;
         ClearWe     <= 1'b0;
         case (state)
            IDLE, HALT: begin
               if (Start) begin
                  state     <= FETCH;
                  InstrAddr <= '0;
                  IrLoad    <= 1'b1;
                  Busy      <= 1'b1;
                  Halted    <= 1'b0;
               end
            end
            FETCH: begin
               OpCode <= InstrData[15:13];
               state  <= DECODE;
            end
            DECODE: begin
               InstrAddr <= InstrAddr + PC_W'(1);
               case (OpCode)
                  OP_ADD, OP_SUB: begin
                     state <= EXEC;
                  end
                  OP_DIV, OP_MUL: begin
                     state    <= EXEC;
                     AluStart <= 1'b1;
                  end
                  OP_READ, OP_WRITE: begin
                     state     <= MEM;
                     MemStrobe <= 1'b1;
                  end
                  OP_CLEAR: begin
                     state     <= CLEAR;
                     ClearWe   <= 1'b1;
                     ClearAddr <= '0;
                  end
                  OP_STOP: begin
                     state  <= HALT;
                     Busy   <= 1'b0;
                     Halted <= 1'b1;
                  end
                  default: begin
                     state <= IDLE;
                     Busy  <= 1'b0;
                  end
               endcase
            end
            EXEC: begin
               if (OpCode == OP_DIV || OpCode == OP_MUL) begin
                  state <= WAIT_ALU;
`ifdef SEQ_ALU_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end else begin
                  state       <= WB;
                  RegWrStrobe <= 1'b1;
               end
            end
            WAIT_ALU: begin
               // AluDone wins over a watchdog expiry in the same cycle.
               if (AluDone) begin
                  state       <= WB;
                  RegWrStrobe <= 1'b1;
               end
`ifdef SEQ_ALU_TIMEOUT_EN
               else if (wait_cnt == TO_LAST) begin
                  state  <= HALT;
                  Erro   <= 1'b1;
                  Busy   <= 1'b0;
                  Halted <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + TO_W'(1);
               end
`endif
            end
            MEM: begin
               if (OpCode == OP_WRITE) begin
                  state  <= FETCH;
                  IrLoad <= 1'b1;
               end else begin
                  state       <= WB;
                  RegWrStrobe <= 1'b1;
               end
            end
            CLEAR: begin
               if (ClearAddr == CLR_LAST) begin
                  state     <= FETCH;
                  ClearAddr <= '0;
                  IrLoad    <= 1'b1;
               end else begin
                  ClearAddr <= ClearAddr + CA_W'(1);
                  ClearWe   <= 1'b1;
               end
            end
            WB: begin
               state  <= FETCH;
               IrLoad <= 1'b1;
            end
            default: begin
               state  <= IDLE;
               Busy   <= 1'b0;
               Halted <= 1'b0;
            end
         endcase
      end
   end

endmodule
